// File: rtl/wb_select_stage.sv
// Write-back select stage: picks write-back data and destination register
// index for the register file, holding the choice in an output register
// behind a valid/ready handshake. Beats with an out-of-range data select or
// dst_sel==3 are consumed but dropped, and are recorded in a sticky flag and a
// saturating counter.
//
//   state   | meaning
//   S_EMPTY | output register holds no transfer (out_valid=0)
//   S_FULL  | output register holds a transfer awaiting out_ready
module wb_select_stage #(
   parameter int DATA_W   = 32,
   parameter int NUM_SRC  = 3,
   parameter int REG_W    = 5,
   parameter int LINK_REG = 31,
   localparam int SEL_W   = (NUM_SRC <= 2) ? 1 : $clog2(NUM_SRC)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [SEL_W-1:0]          data_sel,
   input  logic [REG_W-1:0]          rt,
   input  logic [REG_W-1:0]          rd,
   input  logic [1:0]                dst_sel,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic [REG_W-1:0]          out_dst,
   output logic                      sel_err,
   output logic [7:0]                err_cnt,
   input  logic                      err_clr
);

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [REG_W-1:0]    dst_q, dst_d;
   logic                err_q, err_d;
   logic [7:0]          cnt_q, cnt_d;

   logic                acc;
   logic                sel_ok;
   logic [DATA_W-1:0]   sel_data;
   logic [REG_W-1:0]    sel_dst;

   // Upstream may push whenever the output slot is empty or is draining now.
   assign in_ready = !rst && ((state_q == S_EMPTY) || out_ready);
   assign acc      = in_valid && in_ready;
   assign sel_ok   = ({{(32-SEL_W){1'b0}}, data_sel} < 32'(NUM_SRC)) && (dst_sel != 2'd3);

   // Data source and destination index multiplexers.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (data_sel == SEL_W'(i)) sel_data = src_data[i*DATA_W +: DATA_W];
      end
      case (dst_sel)
         2'd0:    sel_dst = rt;
         2'd1:    sel_dst = rd;
         default: sel_dst = REG_W'(LINK_REG);
      endcase
   end

   // Next-state: output slot occupancy, held beat, and error bookkeeping.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      dst_d   = dst_q;
      err_d   = err_q;
      cnt_d   = cnt_q;

      if (acc && sel_ok) begin
         state_d = S_FULL;
         data_d  = sel_data;
         dst_d   = sel_dst;
      end else if (out_ready) begin
         state_d = S_EMPTY;
      end

      // A fresh drop outranks a simultaneous clear so the event is not lost.
      if (acc && !sel_ok) begin
         err_d = 1'b1;
         if (err_clr)             cnt_d = 8'd1;
         else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end else if (err_clr) begin
         err_d = 1'b0;
         cnt_d = 8'd0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
         data_q  <= '0;
         dst_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         dst_q   <= dst_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid = (state_q == S_FULL);
   assign out_data  = data_q;
   assign out_dst   = dst_q;
   assign sel_err   = err_q;
   assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: directed scenarios followed by random traffic,
// checked by a scoreboard fed from a transaction-level reference model.
module tb_wb_select_stage;
   localparam int DATA_W   = 32;
   localparam int NUM_SRC  = 3;
   localparam int REG_W    = 5;
   localparam int LINK_REG = 31;
   localparam int SEL_W    = 2;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      in_valid;
   logic                      in_ready;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [DATA_W-1:0]         src [NUM_SRC];
   logic [SEL_W-1:0]          data_sel;
   logic [REG_W-1:0]          rt, rd;
   logic [1:0]                dst_sel;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_W-1:0]         out_data;
   logic [REG_W-1:0]          out_dst;
   logic                      sel_err;
   logic [7:0]                err_cnt;
   logic                      err_clr;

   assign src_data = {src[2], src[1], src[0]};

   wb_select_stage #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .REG_W(REG_W), .LINK_REG(LINK_REG)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .src_data(src_data), .data_sel(data_sel), .rt(rt), .rd(rd), .dst_sel(dst_sel),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dst(out_dst),
      .sel_err(sel_err), .err_cnt(err_cnt), .err_clr(err_clr));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic [REG_W-1:0]  r;
   } beat_t;

   beat_t             exp_q[$];
   int                errors = 0;
   int                checks = 0;
   int                n_pop  = 0;
   bit                started = 0;
   logic [DATA_W-1:0] m_data;
   logic [REG_W-1:0]  m_dst;
   logic              m_err;
   logic [7:0]        m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference model: a held-beat queue plus error bookkeeping, from the rules.
   always @(posedge clk) begin : model
      bit    acc, ok;
      beat_t b;
      if (rst) begin
         exp_q.delete();
         m_data  = '0;
         m_dst   = '0;
         m_err   = 1'b0;
         m_cnt   = 8'd0;
         started = 1;
      end else if (started) begin
         acc = in_valid && (exp_q.size() == 0 || out_ready);
         ok  = (int'(data_sel) < NUM_SRC) && (dst_sel != 2'd3);
         if (acc && ok) begin
            b.d = src[data_sel];
            b.r = (dst_sel == 2'd0) ? rt : (dst_sel == 2'd1) ? rd : REG_W'(LINK_REG);
            exp_q.push_back(b);
            m_data = b.d;
            m_dst  = b.r;
         end
         if (acc && !ok) begin
            m_err = 1'b1;
            if (err_clr)           m_cnt = 8'd1;
            else if (m_cnt != 255) m_cnt = m_cnt + 8'd1;
         end else if (err_clr) begin
            m_err = 1'b0;
            m_cnt = 8'd0;
         end
      end
   end

   // Monitor: compares DUT outputs against the model and pops completed transfers.
   always @(negedge clk) begin : monitor
      beat_t b;
      if (started) begin
         check("in_ready", in_ready, !rst && (exp_q.size() == 0 || out_ready));
         if (!rst) begin
            check("out_valid", out_valid, exp_q.size() != 0);
            check("out_data_hold", out_data, m_data);
            check("out_dst_hold", out_dst, m_dst);
            check("sel_err", sel_err, m_err);
            check("err_cnt", err_cnt, m_cnt);
            if (exp_q.size() != 0 && out_ready) begin
               b = exp_q.pop_front();
               n_pop++;
               check("sb_data", out_data, b.d);
               check("sb_dst", out_dst, b.r);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_src();
      for (int i = 0; i < NUM_SRC; i++) src[i] = $urandom;
   endtask

   initial begin
      logic [DATA_W-1:0] last_good;
      logic [DATA_W-1:0] held_a;
      int                pop0;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
      data_sel = '0; dst_sel = '0; rt = '0; rd = '0;
      for (int i = 0; i < NUM_SRC; i++) src[i] = '0;

      // Reset for two cycles
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_data", out_data, 0);
      check("rst_err_cnt", err_cnt, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);

      // Directed select: mem source, link register
      step();
      src[0] = 32'h0000_0005; src[1] = 32'hDEAD_BEEF; src[2] = 32'h0040_0008;
      data_sel = 2'd1; dst_sel = 2'd2; rt = 5'd3; rd = 5'd7; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("sel_valid", out_valid, 1);
      check("sel_data", out_data, 32'hDEAD_BEEF);
      check("sel_dst", out_dst, 31);

      // Backpressure
      step();
      rand_src(); held_a = src[0];
      data_sel = 2'd0; dst_sel = 2'd0; rt = 5'd9; in_valid = 1'b1; out_ready = 1'b0;
      step();
      rand_src(); data_sel = 2'd2; dst_sel = 2'd1; rd = 5'd12;
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         check("bp_in_ready", in_ready, 0);
         check("bp_stable", out_data, held_a);
      end
      step();
      out_ready = 1'b1;
      last_good = src[2];
      @(negedge clk);
      check("bp_release_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_next_loaded", out_data, last_good);

      // Streaming: 8 back-to-back beats
      step();
      pop0 = n_pop;
      for (int i = 0; i < 8; i++) begin
         rand_src();
         data_sel = SEL_W'(i % 3); dst_sel = 2'(i % 2);
         rt = REG_W'($urandom); rd = REG_W'($urandom);
         in_valid = 1'b1;
         if (i == 7) last_good = src[1];
         step();
      end
      in_valid = 1'b0;
      repeat (2) step();
      check("stream_count", n_pop - pop0, 8);

      // Invalid selects
      data_sel = 2'd3; dst_sel = 2'd0; in_valid = 1'b1; rand_src();
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("drop_hold", out_data, last_good);
      check("drop_sel_err", sel_err, 1);
      check("drop_cnt1", err_cnt, 1);
      step();
      in_valid = 1'b1;
      for (int i = 0; i < 259; i++) begin
         data_sel = (i % 2 == 0) ? 2'd3 : 2'd0;
         dst_sel  = (i % 2 == 0) ? 2'd0 : 2'd3;
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("drop_sat", err_cnt, 255);
      step();
      in_valid = 1'b1; data_sel = 2'd3; err_clr = 1'b1;
      step();
      in_valid = 1'b0; err_clr = 1'b0;
      @(negedge clk);
      check("clr_with_drop", err_cnt, 1);
      check("clr_with_drop_err", sel_err, 1);
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      @(negedge clk);
      check("clr_alone_cnt", err_cnt, 0);
      check("clr_alone_err", sel_err, 0);

      // Reset while FULL under backpressure
      step();
      rand_src(); data_sel = 2'd2; dst_sel = 2'd1; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("full_before_rst", out_valid, 1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_full_dropped", out_valid, 0);
      step();
      out_ready = 1'b1;

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         rand_src();
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         data_sel  = SEL_W'($urandom_range(3));
         dst_sel   = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
         rt        = REG_W'($urandom);
         rd        = REG_W'($urandom);
         err_clr   = ($urandom_range(15) == 0);
         rst       = ($urandom_range(150) == 0);
         step();
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
      repeat (3) step();
      check("drain_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
